// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: result-source encodings and the E-stage control bundle.
package riscv_pkg;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned RES_SRC_W  = 2;

  typedef enum logic [RES_SRC_W-1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  // Control fields carried from decode into execute.
  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [RES_SRC_W-1:0]  result_src;
  } ctrl_t;

  // All-zero control is a harmless NOP, so a bubble is simply this value.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_execute_reg_hazard_detect.sv
// Load-use hazard detection between the instruction in E and the one in D.
module hazard_detect
  import riscv_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic                 valid_e,
  input  logic                 reg_write_e,
  input  logic [RES_SRC_W-1:0] result_src_e,
  input  logic [REG_AW-1:0]    rd_e,
  input  logic [REG_AW-1:0]    rs1_d,
  input  logic [REG_AW-1:0]    rs2_d,
  output logic                 load_use_c
);

  logic is_load_c;
  logic rd_nonzero_c;
  logic src_match_c;

  // A valid load writing a real register that D is about to read.
  always_comb begin
    is_load_c    = valid_e & reg_write_e & (result_src_e == RES_SRC_W'(RES_LOAD));
    rd_nonzero_c = (rd_e != '0);
    src_match_c  = (rd_e == rs1_d) | (rd_e == rs2_d);
    load_use_c   = is_load_c & rd_nonzero_c & src_match_c;
  end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with load-use bubble insertion, flush handling,
// upstream stall/flush generation and a saturating bubble counter.
module decode_execute_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic [ALU_CTRL_W-1:0] ALUControlD,
  input  logic                  ALUSrcD,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic [RES_SRC_W-1:0]  ResultSrcD,
  input  logic [REG_AW-1:0]     Rs1D,
  input  logic [REG_AW-1:0]     Rs2D,
  input  logic [REG_AW-1:0]     RdD,
  input  logic [XLEN-1:0]       RD1D,
  input  logic [XLEN-1:0]       RD2D,
  input  logic [XLEN-1:0]       ImmExtD,
  input  logic [XLEN-1:0]       PCD,
  input  logic [XLEN-1:0]       PCPlus4D,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  ALUSrcE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [RES_SRC_W-1:0]  ResultSrcE,
  output logic [REG_AW-1:0]     Rs1E,
  output logic [REG_AW-1:0]     Rs2E,
  output logic [REG_AW-1:0]     RdE,
  output logic [XLEN-1:0]       RD1E,
  output logic [XLEN-1:0]       RD2E,
  output logic [XLEN-1:0]       ImmExtE,
  output logic [XLEN-1:0]       PCE,
  output logic [XLEN-1:0]       PCPlus4E,
  output logic                  ValidE,
  output logic                  stall_f_o,
  output logic                  stall_d_o,
  output logic                  flush_d_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_t             ctrl_q,  ctrl_n,  ctrl_d;
  logic              valid_q, valid_n;
  logic [REG_AW-1:0] rs1_q,   rs1_n;
  logic [REG_AW-1:0] rs2_q,   rs2_n;
  logic [REG_AW-1:0] rd_q,    rd_n;
  logic [XLEN-1:0]   rd1_q,   rd1_n;
  logic [XLEN-1:0]   rd2_q,   rd2_n;
  logic [XLEN-1:0]   imm_q,   imm_n;
  logic [XLEN-1:0]   pc_q,    pc_n;
  logic [XLEN-1:0]   pc4_q,   pc4_n;
  logic [CNT_W-1:0]  cnt_q;

  logic load_use_c;
  logic bubble_c;
  logic load_c;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .valid_e      (valid_q),
    .reg_write_e  (ctrl_q.reg_write),
    .result_src_e (ctrl_q.result_src),
    .rd_e         (rd_q),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .load_use_c   (load_use_c)
  );

  // Hold wins over everything; flush and load-use both turn into a bubble.
  always_comb begin
    bubble_c  = ~hold_i & (flush_i | load_use_c);
    load_c    = ~hold_i & ~bubble_c;
    stall_f_o = hold_i | (load_use_c & ~flush_i);
    stall_d_o = hold_i | (load_use_c & ~flush_i);
    flush_d_o = flush_i & ~hold_i;
  end

  // Pack the decode control fields into the E-stage bundle.
  always_comb begin
    ctrl_d             = CTRL_NOP;
    ctrl_d.alu_control = ALUControlD;
    ctrl_d.alu_src     = ALUSrcD;
    ctrl_d.reg_write   = RegWriteD;
    ctrl_d.mem_write   = MemWriteD;
    ctrl_d.jump        = JumpD;
    ctrl_d.branch      = BranchD;
    ctrl_d.result_src  = ResultSrcD;
  end

  // Next E contents: keep by default, zero on a bubble, take D on a normal advance.
  always_comb begin
    ctrl_n  = ctrl_q;
    valid_n = valid_q;
    rs1_n   = rs1_q;
    rs2_n   = rs2_q;
    rd_n    = rd_q;
    rd1_n   = rd1_q;
    rd2_n   = rd2_q;
    imm_n   = imm_q;
    pc_n    = pc_q;
    pc4_n   = pc4_q;
    if (bubble_c) begin
      ctrl_n  = CTRL_NOP;
      valid_n = 1'b0;
      rs1_n   = '0;
      rs2_n   = '0;
      rd_n    = '0;
      rd1_n   = '0;
      rd2_n   = '0;
      imm_n   = '0;
      pc_n    = '0;
      pc4_n   = '0;
    end else if (load_c) begin
      ctrl_n  = ctrl_d;
      valid_n = 1'b1;
      rs1_n   = Rs1D;
      rs2_n   = Rs2D;
      rd_n    = RdD;
      rd1_n   = RD1D;
      rd2_n   = RD2D;
      imm_n   = ImmExtD;
      pc_n    = PCD;
      pc4_n   = PCPlus4D;
    end
  end

  // E-stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_n;
      valid_q <= valid_n;
      rs1_q   <= rs1_n;
      rs2_q   <= rs2_n;
      rd_q    <= rd_n;
      rd1_q   <= rd1_n;
      rd2_q   <= rd2_n;
      imm_q   <= imm_n;
      pc_q    <= pc_n;
      pc4_q   <= pc4_n;
    end
  end

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bubble_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Unpack registered state onto the E outputs.
  always_comb begin
    ALUControlE  = ctrl_q.alu_control;
    ALUSrcE      = ctrl_q.alu_src;
    RegWriteE    = ctrl_q.reg_write;
    MemWriteE    = ctrl_q.mem_write;
    JumpE        = ctrl_q.jump;
    BranchE      = ctrl_q.branch;
    ResultSrcE   = ctrl_q.result_src;
    ValidE       = valid_q;
    Rs1E         = rs1_q;
    Rs2E         = rs2_q;
    RdE          = rd_q;
    RD1E         = rd1_q;
    RD2E         = rd2_q;
    ImmExtE      = imm_q;
    PCE          = pc_q;
    PCPlus4E     = pc4_q;
    bubble_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg (counter narrowed to 4 bits to reach saturation).
module tb_decode_execute_reg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              hold_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [3:0]        ALUControlD = '0;
  logic              ALUSrcD = 1'b0, RegWriteD = 1'b0, MemWriteD = 1'b0, JumpD = 1'b0, BranchD = 1'b0;
  logic [1:0]        ResultSrcD = '0;
  logic [REG_AW-1:0] Rs1D = '0, Rs2D = '0, RdD = '0;
  logic [XLEN-1:0]   RD1D = '0, RD2D = '0, ImmExtD = '0, PCD = '0, PCPlus4D = '0;

  logic [3:0]        ALUControlE;
  logic              ALUSrcE, RegWriteE, MemWriteE, JumpE, BranchE;
  logic [1:0]        ResultSrcE;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic              ValidE, stall_f_o, stall_d_o, flush_d_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  decode_execute_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ResultSrcD(ResultSrcD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ResultSrcE(ResultSrcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ValidE(ValidE),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .flush_d_o(flush_d_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a D-stage instruction.
  task automatic drive(input logic [3:0] alu, input logic rw, input logic [1:0] rsrc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] rd1);
    ALUControlD = alu; RegWriteD = rw; ResultSrcD = rsrc;
    ALUSrcD = 1'b0; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b0;
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RD1D = rd1; RD2D = 32'h0000_1111;
    ImmExtD = 32'h0000_0004; PCD = 32'h0000_0100; PCPlus4D = 32'h0000_0104;
  endtask

  initial begin
    // Reset asserted mid-cycle with every D input at 1.
    ALUControlD = '1; ALUSrcD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1;
    BranchD = 1'b1; ResultSrcD = '1; Rs1D = '1; Rs2D = '1; RdD = '1;
    RD1D = '1; RD2D = '1; ImmExtD = '1; PCD = '1; PCPlus4D = '1;
    tick();
    #3 rst = 1'b1;
    #1;
    check("rst_alu",   64'(ALUControlE), 64'h0);
    check("rst_regw",  64'(RegWriteE), 64'h0);
    check("rst_rd",    64'(RdE), 64'h0);
    check("rst_pc4",   64'(PCPlus4E), 64'h0);
    check("rst_valid", 64'(ValidE), 64'h0);
    check("rst_cnt",   64'(bubble_cnt_o), 64'h0);
    check("rst_stall", 64'(stall_f_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("pass_alu",   64'(ALUControlE), 64'hF);
    check("pass_valid", 64'(ValidE), 64'h1);
    check("pass_rs2",   64'(Rs2E), 64'h1F);
    check("pass_imm",   64'(ImmExtE), 64'hFFFF_FFFF);
    check("pass_jump",  64'(JumpE), 64'h1);

    // Load-use: lw x5, then consumer reading x5.
    drive(4'h0, 1'b1, 2'b01, 5'd1, 5'd2, 5'd5, 32'h0);
    tick();
    drive(4'h2, 1'b1, 2'b00, 5'd5, 5'd3, 5'd6, 32'h0000_00AA);
    #1;
    check("lu_stall_f", 64'(stall_f_o), 64'h1);
    check("lu_stall_d", 64'(stall_d_o), 64'h1);
    check("lu_flush_d", 64'(flush_d_o), 64'h0);
    tick();
    check("lu_bub_valid", 64'(ValidE), 64'h0);
    check("lu_bub_alu",   64'(ALUControlE), 64'h0);
    check("lu_bub_regw",  64'(RegWriteE), 64'h0);
    check("lu_cnt",       64'(bubble_cnt_o), 64'h1);
    check("lu_no_stall2", 64'(stall_f_o), 64'h0);
    tick();
    check("lu_add_alu",   64'(ALUControlE), 64'h2);
    check("lu_add_rd",    64'(RdE), 64'h6);
    check("lu_add_rd1",   64'(RD1E), 64'hAA);
    check("lu_add_valid", 64'(ValidE), 64'h1);

    // x0 destination never stalls.
    drive(4'h0, 1'b1, 2'b01, 5'd1, 5'd2, 5'd0, 32'h0);
    tick();
    drive(4'h3, 1'b1, 2'b00, 5'd0, 5'd4, 5'd7, 32'h0);
    #1;
    check("x0_stall", 64'(stall_d_o), 64'h0);
    tick();
    check("x0_alu", 64'(ALUControlE), 64'h3);
    check("x0_rd",  64'(RdE), 64'h7);
    check("x0_cnt", 64'(bubble_cnt_o), 64'h1);

    // Flush and load-use together: flush wins, one bubble.
    drive(4'h0, 1'b1, 2'b01, 5'd1, 5'd2, 5'd9, 32'h0);
    tick();
    drive(4'h4, 1'b1, 2'b00, 5'd8, 5'd9, 5'd10, 32'h0);
    flush_i = 1'b1;
    #1;
    check("fl_stall_f", 64'(stall_f_o), 64'h0);
    check("fl_stall_d", 64'(stall_d_o), 64'h0);
    check("fl_flush_d", 64'(flush_d_o), 64'h1);
    tick();
    flush_i = 1'b0;
    check("fl_valid", 64'(ValidE), 64'h0);
    check("fl_alu",   64'(ALUControlE), 64'h0);
    check("fl_rs2",   64'(Rs2E), 64'h0);
    check("fl_cnt",   64'(bubble_cnt_o), 64'h2);

    // Hold for 3 cycles with flush pending and D changing.
    drive(4'h5, 1'b1, 2'b00, 5'd1, 5'd2, 5'd10, 32'hDEAD_BEEF);
    tick();
    hold_i = 1'b1;
    flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'(6 + i), 1'b1, 2'b00, 5'd3, 5'd4, 5'(11 + i), 32'(i));
      #1;
      check("hold_flush_d", 64'(flush_d_o), 64'h0);
      check("hold_stall_f", 64'(stall_f_o), 64'h1);
      tick();
      check("hold_rd",  64'(RdE), 64'hA);
      check("hold_alu", 64'(ALUControlE), 64'h5);
      check("hold_rd1", 64'(RD1E), 64'hDEAD_BEEF);
      check("hold_cnt", 64'(bubble_cnt_o), 64'h2);
    end
    hold_i = 1'b0;
    #1;
    check("unhold_flush_d", 64'(flush_d_o), 64'h1);
    check("unhold_stall",   64'(stall_d_o), 64'h0);
    tick();
    flush_i = 1'b0;
    check("unhold_valid", 64'(ValidE), 64'h0);
    check("unhold_rd",    64'(RdE), 64'h0);
    check("unhold_cnt",   64'(bubble_cnt_o), 64'h3);

    // Reset in the middle of a load-use stall.
    drive(4'h0, 1'b1, 2'b01, 5'd1, 5'd2, 5'd5, 32'h0);
    tick();
    drive(4'h7, 1'b1, 2'b00, 5'd5, 5'd5, 5'd12, 32'h0);
    #1;
    check("mid_stall", 64'(stall_f_o), 64'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", 64'(stall_f_o), 64'h0);
    check("mid_rst_cnt",   64'(bubble_cnt_o), 64'h0);
    check("mid_rst_rd",    64'(RdE), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_stall", 64'(stall_d_o), 64'h0);
    tick();
    check("rel_alu",   64'(ALUControlE), 64'h7);
    check("rel_valid", 64'(ValidE), 64'h1);
    check("rel_cnt",   64'(bubble_cnt_o), 64'h0);

    // Saturation: 20 consecutive flushes on a 4-bit counter.
    flush_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("sat_14", 64'(bubble_cnt_o), 64'hE);
      if (i == 15) check("sat_15", 64'(bubble_cnt_o), 64'hF);
    end
    check("sat_20", 64'(bubble_cnt_o), 64'hF);
    flush_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
